// File: rtl/lc3b_types.sv
// Shared LC-3b memory-bus types and the bridge state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [14:0] lc3b_waddr;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    XFER = 3'd2,
    CAPT = 3'd3,
    RESP = 3'd4
  } bridge_state_e;

  // Lane mask driven to the SRAM for reads; the CPU mask only matters for writes.
  localparam lc3b_mem_wmask READ_LANES = 2'b11;

endpackage

// File: rtl/mem_bridge_if.sv
// CPU-side memory bus: request strobes, address/data and the registered response.
interface mem_bridge_if;

  lc3b_types::lc3b_word      mem_address;
  logic                      mem_read;
  logic                      mem_write;
  lc3b_types::lc3b_mem_wmask mem_byte_enable;
  lc3b_types::lc3b_word      mem_wdata;
  lc3b_types::lc3b_word      mem_rdata;
  logic                      mem_resp;

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

// File: rtl/wait_counter.sv
// 4-bit loadable down-counter with zero/one flags; saturates at zero.
module wait_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       is_zero,
  output logic       is_one
);

  logic [3:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != 4'd0)) begin
      count_q <= count_q - 4'd1;
    end
  end

  assign is_zero = (count_q == 4'd0);
  assign is_one  = (count_q == 4'd1);

endmodule

// File: rtl/mem_bridge.sv
// CPU-to-SRAM bridge: programmable wait states, single-cycle SRAM strobe,
// registered read data and a one-cycle completion pulse.
module mem_bridge
  import lc3b_types::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_bridge_if.slave   cpu,
  output lc3b_waddr     sram_addr,
  output logic          sram_ce,
  output logic          sram_we,
  output lc3b_mem_wmask sram_be,
  output lc3b_word      sram_wdata,
  input  lc3b_word      sram_rdata,
  output logic          req_err,
  output lc3b_word      access_count
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  bridge_state_e state_q, state_d;
  logic          op_write_q, op_write_d;
  logic          accept, live_strobe;
  logic          cnt_load, cnt_dec, cnt_zero, cnt_one;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = cpu.mem_address[0];

  wait_counter u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (WAIT_LD),
    .dec      (cnt_dec),
    .is_zero  (cnt_zero),
    .is_one   (cnt_one)
  );

  // The request stays alive in WAIT only while the CPU keeps its original strobe up.
  assign live_strobe = op_write_q ? cpu.mem_write : cpu.mem_read;
  assign op_write_d  = accept ? cpu.mem_write : op_write_q;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu.mem_read || cpu.mem_write) begin
          accept   = 1'b1;
          cnt_load = 1'b1;
          state_d  = (WAIT_LD == 4'd0) ? XFER : WAIT;
        end
      end
      WAIT: begin
        if (!live_strobe) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_one || cnt_zero) state_d = XFER;
        end
      end
      XFER:    state_d = op_write_q ? RESP : CAPT;
      CAPT:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobes are registered from the next state so they line up exactly with XFER/RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_write_q    <= 1'b0;
      sram_addr     <= '0;
      sram_wdata    <= '0;
      sram_be       <= 2'b00;
      sram_ce       <= 1'b0;
      sram_we       <= 1'b0;
      cpu.mem_resp  <= 1'b0;
      cpu.mem_rdata <= '0;
      req_err       <= 1'b0;
      access_count  <= '0;
    end else begin
      sram_ce      <= (state_d == XFER);
      sram_we      <= (state_d == XFER) && op_write_d;
      cpu.mem_resp <= (state_d == RESP);
      if (accept) begin
        op_write_q <= cpu.mem_write;
        sram_addr  <= cpu.mem_address[15:1];
        sram_wdata <= cpu.mem_wdata;
        sram_be    <= cpu.mem_write ? cpu.mem_byte_enable : READ_LANES;
        if (cpu.mem_read && cpu.mem_write) req_err <= 1'b1;
      end
      if (state_q == CAPT) cpu.mem_rdata <= sram_rdata;
      if (state_d == RESP) access_count <= access_count + 16'd1;
    end
  end

endmodule
